// File: rtl/shift_sequencer.sv
// shift_sequencer
// Breaks a shift request into steps of at most 3 positions. It applies one
// step per clock to an internal work register, then presents the result on
// d_out along with a one-cycle done pulse.
//
// Optional feature macro: SHIFT_SEQ_ROR_EN
//   defined   : op 11 rotates right by amount, stepping like the other ops
//   undefined : op 11 passes d_in straight through (IDLE -> DONE)
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   start    in   request strobe, sampled only in IDLE
//   op       in   2   00 LSL, 01 LSR, 10 ASR, 11 ROR / pass-through
//   d_in     in   8   operand, latched on accepted start
//   amount   in   AMT_W total shift amount, latched on accepted start
//   busy     out  high whenever not IDLE
//   done     out  one-cycle pulse, d_out valid
//   d_out    out  8   result register, holds the last result
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for start
// S_SHIFT | applying one step of up to 3 positions per clock
// S_DONE  | d_out valid, done pulsed for one cycle
module shift_sequencer #(
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [7:0]       d_in,
   input  logic [AMT_W-1:0] amount,
   output logic             busy,
   output logic             done,
   output logic [7:0]       d_out
);

   // The step shifter is 2 bits wide, so STEP_MAX cannot be a parameter.
   localparam int               STEP_MAX   = 3;
   localparam logic [AMT_W-1:0] STEP_MAX_W = AMT_W'(STEP_MAX);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       work_q, work_d;
   logic [AMT_W-1:0] rem_q, rem_d;
   logic [1:0]       op_q, op_d;
   logic [7:0]       dout_q, dout_d;

   logic [1:0]       step;
   logic [7:0]       shifted;
   logic             zero_req;

   assign step = (rem_q >= STEP_MAX_W) ? 2'd3 : rem_q[1:0];

   always_comb begin
      shifted = work_q;
      case (op_q)
         2'b00:   shifted = work_q << step;
         2'b01:   shifted = work_q >> step;
         2'b10:   shifted = $unsigned($signed(work_q) >>> step);
`ifdef SHIFT_SEQ_ROR_EN
         2'b11:   shifted = 8'(({work_q, work_q}) >> step);
`endif
         default: shifted = work_q;
      endcase
   end

`ifdef SHIFT_SEQ_ROR_EN
   assign zero_req = (amount == '0);
`else
   // Op 11 is a pass-through when rotate support is not built in.
   assign zero_req = (amount == '0) || (op == 2'b11);
`endif

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      rem_d   = rem_q;
      op_d    = op_q;
      dout_d  = dout_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               work_d = d_in;
               rem_d  = amount;
               op_d   = op;
               if (zero_req) begin
                  dout_d  = d_in;
                  state_d = S_DONE;
               end else begin
                  state_d = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            work_d = shifted;
            rem_d  = rem_q - AMT_W'(step);
            if (rem_q == AMT_W'(step)) begin
               dout_d  = shifted;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         work_q  <= 8'h00;
         rem_q   <= '0;
         op_q    <= 2'b00;
         dout_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         rem_q   <= rem_d;
         op_q    <= op_d;
         dout_q  <= dout_d;
      end
   end

   assign busy  = (state_q != S_IDLE);
   assign done  = (state_q == S_DONE);
   assign d_out = dout_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic [1:0] op;
   logic [7:0] d_in;
   logic [2:0] amount;
   logic       busy;
   logic       done;
   logic [7:0] d_out;

   int tests = 0;
   int fails = 0;

   shift_sequencer #(.AMT_W(3)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .op      (op),
      .d_in    (d_in),
      .amount  (amount),
      .busy    (busy),
      .done    (done),
      .d_out   (d_out)
   );

   always #5 clk = ~clk;

   // Reference result, built from the shift definitions using integer arithmetic.
   function automatic logic [7:0] ref_result(input logic [1:0] r_op, input logic [7:0] r_d,
                                             input int r_amt);
      int v;
      int r;
      v = 0;
      case (r_op)
         2'd0: v = (int'(r_d) << r_amt) & 255;
         2'd1: v = int'(r_d) >> r_amt;
         2'd2: begin
            v = r_d[7] ? int'(r_d) - 256 : int'(r_d);
            v = (v >>> r_amt) & 255;
         end
         default: begin
`ifdef SHIFT_SEQ_ROR_EN
            r = r_amt % 8;
            v = ((int'(r_d) >> r) | (int'(r_d) << (8 - r))) & 255;
`else
            r = 0;
            v = int'(r_d) + r;
`endif
         end
      endcase
      return v[7:0];
   endfunction

   function automatic int ref_latency(input logic [1:0] r_op, input int r_amt);
      if (r_amt == 0) return 1;
`ifndef SHIFT_SEQ_ROR_EN
      if (r_op == 2'd3) return 1;
`endif
      return (r_amt + 2) / 3 + 1;
   endfunction

   // The caller invokes this between clock edges. It returns one time unit after the edge on which done was seen.
   task automatic run_req(input logic [1:0] r_op, input logic [7:0] r_d, input logic [2:0] r_amt,
                          input bit mid_start, output int lat, output logic [7:0] res,
                          output bit busy_ok);
      lat     = -1;
      res     = 8'h00;
      busy_ok = 1'b1;
      op      = r_op;
      d_in    = r_d;
      amount  = r_amt;
      start   = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         #1;
         op     = 2'($urandom);
         d_in   = 8'($urandom);
         amount = 3'($urandom);
         start  = mid_start && (e == 2);
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (done === 1'b1) begin
            lat = e;
            res = d_out;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic watch(input int n, input logic [7:0] hold, output int ndone,
                        output bit busy_seen, output bit dout_moved);
      ndone      = 0;
      busy_seen  = 1'b0;
      dout_moved = 1'b0;
      for (int e = 0; e < n; e++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) ndone++;
         if (busy !== 1'b0) busy_seen = 1'b1;
         if (d_out !== hold) dout_moved = 1'b1;
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      start   = 1'b0;
      op      = 2'd0;
      d_in    = 8'h00;
      amount  = 3'd0;
      repeat (3) @(posedge clk);
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
      tests++; if (d_out !== 8'h00) begin fails++; $display("FAIL reset_dout got %h want 00", d_out); end
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_zero_amount;
      int lat; logic [7:0] res; bit bok; int nd; bit bs; bit dm;
      run_req(2'd1, 8'hF0, 3'd0, 1'b0, lat, res, bok);
      tests++; if (lat !== 1) begin fails++; $display("FAIL zero_latency got %0d want 1", lat); end
      tests++; if (res !== 8'hF0) begin fails++; $display("FAIL zero_dout got %h want f0", res); end
      tests++; if (bok !== 1'b1) begin fails++; $display("FAIL zero_busy got %b want 1", bok); end
      watch(3, 8'hF0, nd, bs, dm);
      tests++; if (bs !== 1'b0) begin fails++; $display("FAIL zero_busy_after got %b want 0", bs); end
      tests++; if (nd !== 0) begin fails++; $display("FAIL zero_extra_done got %0d want 0", nd); end
   endtask

   task automatic test_asr;
      int lat; logic [7:0] res; bit bok; int nd; bit bs; bit dm;
      run_req(2'd2, 8'h96, 3'd5, 1'b0, lat, res, bok);
      tests++; if (lat !== 3) begin fails++; $display("FAIL asr_latency got %0d want 3", lat); end
      tests++; if (res !== 8'hFC) begin fails++; $display("FAIL asr_dout got %h want fc", res); end
      tests++; if (bok !== 1'b1) begin fails++; $display("FAIL asr_busy got %b want 1", bok); end
      watch(1, 8'hFC, nd, bs, dm);
   endtask

   task automatic test_lsl_ignore_start;
      int lat; logic [7:0] res; bit bok; int nd; bit bs; bit dm;
      run_req(2'd0, 8'h81, 3'd7, 1'b1, lat, res, bok);
      tests++; if (lat !== 4) begin fails++; $display("FAIL lsl_latency got %0d want 4", lat); end
      tests++; if (res !== 8'h80) begin fails++; $display("FAIL lsl_dout got %h want 80", res); end
      watch(6, 8'h80, nd, bs, dm);
      tests++; if (nd !== 0) begin fails++; $display("FAIL lsl_extra_done got %0d want 0", nd); end
      tests++; if (dm !== 1'b0) begin fails++; $display("FAIL lsl_dout_held got %b want 0", dm); end
      tests++; if (bs !== 1'b0) begin fails++; $display("FAIL lsl_queued_start got %b want 0", bs); end
   endtask

   task automatic test_back_to_back;
      int lat; logic [7:0] res; bit bok; int nd; bit bs; bit dm;
      run_req(2'd1, 8'h80, 3'd3, 1'b0, lat, res, bok);
      tests++; if (lat !== 2) begin fails++; $display("FAIL b2b1_latency got %0d want 2", lat); end
      tests++; if (res !== 8'h10) begin fails++; $display("FAIL b2b1_dout got %h want 10", res); end
      @(posedge clk);
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle_busy got %b want 0", busy); end
      run_req(2'd2, 8'h80, 3'd7, 1'b0, lat, res, bok);
      tests++; if (lat !== 4) begin fails++; $display("FAIL b2b2_latency got %0d want 4", lat); end
      tests++; if (res !== 8'hFF) begin fails++; $display("FAIL b2b2_dout got %h want ff", res); end
      watch(3, 8'hFF, nd, bs, dm);
      tests++; if (nd !== 0) begin fails++; $display("FAIL b2b_extra_done got %0d want 0", nd); end
   endtask

   task automatic test_reset_mid;
      int nd; bit bs; bit dm;
      op      = 2'd0;
      d_in    = 8'h01;
      amount  = 3'd6;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy_before got %b want 1", busy); end
      #2;
      reset_n = 1'b0;
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy got %b want 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL mid_rst_done got %b want 0", done); end
      tests++; if (d_out !== 8'h00) begin fails++; $display("FAIL mid_rst_dout got %h want 00", d_out); end
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      watch(10, 8'h00, nd, bs, dm);
      tests++; if (nd !== 0) begin fails++; $display("FAIL mid_rst_done_after got %0d want 0", nd); end
      tests++; if (bs !== 1'b0) begin fails++; $display("FAIL mid_rst_busy_after got %b want 0", bs); end
      tests++; if (dm !== 1'b0) begin fails++; $display("FAIL mid_rst_dout_after got %b want 0", dm); end
   endtask

   task automatic test_op11;
      int lat; logic [7:0] res; bit bok; int nd; bit bs; bit dm;
      logic [7:0] want_d;
      int want_l;
`ifdef SHIFT_SEQ_ROR_EN
      want_d = 8'hC0;
      want_l = 2;
`else
      want_d = 8'h81;
      want_l = 1;
`endif
      run_req(2'd3, 8'h81, 3'd1, 1'b0, lat, res, bok);
      tests++; if (lat !== want_l) begin fails++; $display("FAIL op11_latency got %0d want %0d", lat, want_l); end
      tests++; if (res !== want_d) begin fails++; $display("FAIL op11_dout got %h want %h", res, want_d); end
      watch(1, want_d, nd, bs, dm);
   endtask

   task automatic test_random;
      int lat; logic [7:0] res; bit bok; int nd; bit bs; bit dm;
      logic [1:0] r_op; logic [7:0] r_d; logic [2:0] r_amt;
      logic [7:0] want_d;
      int want_l;
      for (int i = 0; i < 40; i++) begin
         r_op   = 2'($urandom);
         r_d    = 8'($urandom);
         r_amt  = 3'($urandom);
         want_d = ref_result(r_op, r_d, int'(r_amt));
         want_l = ref_latency(r_op, int'(r_amt));
         run_req(r_op, r_d, r_amt, 1'b0, lat, res, bok);
         tests++;
         if (res !== want_d) begin
            fails++;
            $display("FAIL rand_dout op=%0d d=%h amt=%0d got %h want %h", r_op, r_d, r_amt, res, want_d);
         end
         tests++;
         if (lat !== want_l) begin
            fails++;
            $display("FAIL rand_latency op=%0d amt=%0d got %0d want %0d", r_op, r_amt, lat, want_l);
         end
         tests++;
         if (bok !== 1'b1) begin
            fails++;
            $display("FAIL rand_busy op=%0d amt=%0d got %b want 1", r_op, r_amt, bok);
         end
         watch(1 + (i % 2), want_d, nd, bs, dm);
      end
   endtask

   initial begin
      test_reset();
      test_zero_amount();
      test_asr();
      test_lsl_ignore_start();
      test_back_to_back();
      test_reset_mid();
      test_op11();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
